led_blink_arbiter: RTL and testbench

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

---
 rtl/led_blink_arbiter.sv | 163 ++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that lends one shared LED to four requesters, each of which
// asks for a number of on/off blinks and receives a one-cycle done pulse when they finish.
module led_blink_arbiter #(
  parameter int unsigned ON_CYC  = 25000000,
  parameter int unsigned OFF_CYC = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_cnt,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic        led
);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic        led_q, led_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phase_q, phase_d;

  logic [1:0]  idx;
  logic [1:0]  pick;
  logic        pick_vld;
  logic [3:0]  pick_cnt;
  logic        withdrawn;

  // First set request bit, searching upward from ptr with wrap-around.
  always_comb begin
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    pick_cnt = req_cnt[{pick, 2'b00} +: 4];
  end

  assign withdrawn = (req & gnt_q) == 4'b0000;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    led_d   = led_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        led_d = 1'b0;
        if (pick_vld) begin
          gnt_d   = 4'b0001 << pick;
          cnt_d   = pick_cnt;
          phase_d = '0;
          ptr_d   = pick + 2'd1;
          if (pick_cnt == 4'd0) begin
            state_d = StDone;
            led_d   = 1'b0;
          end else begin
            state_d = StOn;
            led_d   = 1'b1;
          end
        end
      end

      StOn: begin
        if (withdrawn) begin
          state_d = StIdle;
          gnt_d   = '0;
          led_d   = 1'b0;
          phase_d = '0;
        end else if (phase_q == ON_CYC - 32'd1) begin
          state_d = StOff;
          led_d   = 1'b0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      StOff: begin
        if (withdrawn) begin
          state_d = StIdle;
          gnt_d   = '0;
          led_d   = 1'b0;
          phase_d = '0;
        end else if (phase_q == OFF_CYC - 32'd1) begin
          phase_d = '0;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StDone;
            gnt_d   = '0;
            done_d  = gnt_q;
          end else begin
            state_d = StOn;
            led_d   = 1'b1;
          end
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      StDone: begin
        // A zero-count grant arrives here with gnt still set: hold it one cycle, then pulse.
        if (gnt_q != 4'b0000) begin
          done_d = gnt_q;
          gnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        led_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: table vectors, directed corner sequences and random traffic
// compared every cycle against a grant-schedule reference model.
module tb_led_blink_arbiter;

  localparam int unsigned ON  = 3;
  localparam int unsigned OFF = 2;
  localparam int unsigned PER = ON + OFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_cnt = '0;
  logic [3:0]  gnt, done;
  logic        busy, led;

  int n_chk = 0;
  int n_fail = 0;

  led_blink_arbiter #(.ON_CYC(ON), .OFF_CYC(OFF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_cnt (req_cnt),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a service is "granted at edge k=0"; everything else follows from
  // counting edges since that grant.
  typedef struct packed {
    logic        act;
    logic [1:0]  who;
    logic [3:0]  n;
    int unsigned k;
    logic [1:0]  ptr;
  } mstate_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic       led;
  } outs_t;

  mstate_t ms;

  function automatic int unsigned span(mstate_t s);
    return (s.n == 4'd0) ? 1 : 32'(s.n) * PER;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic [3:0] r, logic [15:0] c);
    mstate_t    ns;
    logic [1:0] i;
    logic       found;
    ns    = s;
    found = 1'b0;
    if (s.act) begin
      if (s.k >= span(s)) ns.act = 1'b0;
      else if (s.n != 4'd0 && !r[s.who]) ns.act = 1'b0;
      else ns.k = s.k + 1;
    end else if (r != 4'b0000) begin
      for (int j = 0; j < 4; j++) begin
        i = s.ptr + 2'(j);
        if (!found && r[i]) begin
          found  = 1'b1;
          ns.who = i;
          ns.n   = c[4*int'(i) +: 4];
        end
      end
      ns.act = 1'b1;
      ns.k   = 0;
      ns.ptr = ns.who + 2'd1;
    end
    return ns;
  endfunction

  function automatic outs_t model_out(mstate_t s);
    outs_t o;
    o = '0;
    if (s.act) begin
      o.busy = 1'b1;
      if (s.k >= span(s)) begin
        o.done = 4'b0001 << s.who;
      end else begin
        o.gnt = 4'b0001 << s.who;
        o.led = (s.n != 4'd0) && ((s.k % PER) < ON);
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '0;
    else ms <= model_step(ms, req, req_cnt);
  end

  // Continuous comparison against the model plus structural invariants.
  always @(negedge clk) begin
    outs_t e;
    e = model_out(ms);
    check("gnt_vs_model", 32'(gnt), 32'(e.gnt));
    check("done_vs_model", 32'(done), 32'(e.done));
    check("busy_vs_model", 32'(busy), 32'(e.busy));
    check("led_vs_model", 32'(led), 32'(e.led));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("done_onehot0", 32'($onehot0(done)), 32'd1);
    check("led_implies_busy", 32'(!led || busy), 32'd1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] cnt;
    logic [3:0]  gnt;
    int          dur;
    int          leds;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    req     = '0;
    req_cnt = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int lat);
    lat = 0;
    while (gnt == 4'b0000 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    g = gnt;
  endtask

  task automatic wait_done(output int dur, output int leds, output logic [15:0] pat,
                           output logic [3:0] d);
    dur  = 0;
    leds = 0;
    pat  = '0;
    while (done == 4'b0000 && dur < 200) begin
      leds += int'(led);
      pat = {pat[14:0], led};
      @(negedge clk);
      dur++;
    end
    d = done;
  endtask

  task automatic rnd_drive();
    outs_t e;
    e = model_out(ms);
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (e.done[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(63) == 0) begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(7) == 0) begin
        req[i] = 1'b1;
        req_cnt[4*i +: 4] = 4'($urandom_range(3));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  g, d;
    logic [15:0] pat;
    int          lat, dur, leds;
    logic [3:0]  rr_exp[5];

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    vecs[0] = '{req: 4'b0001, cnt: 16'h0002, gnt: 4'b0001, dur: 10, leds: 6};
    vecs[1] = '{req: 4'b0100, cnt: 16'h0000, gnt: 4'b0100, dur: 1,  leds: 0};
    vecs[2] = '{req: 4'b1010, cnt: 16'h3010, gnt: 4'b0010, dur: 5,  leds: 3};
    vecs[3] = '{req: 4'b1000, cnt: 16'h4000, gnt: 4'b1000, dur: 20, leds: 12};
    vecs[4] = '{req: 4'b1111, cnt: 16'hFFFF, gnt: 4'b0001, dur: 75, leds: 45};
    vecs[5] = '{req: 4'b1100, cnt: 16'h0100, gnt: 4'b0100, dur: 5,  leds: 3};

    @(negedge clk);
    check("reset_outputs", 32'({gnt, done, busy, led}), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      do_reset();
      req     = vecs[v].req;
      req_cnt = vecs[v].cnt;
      wait_grant(g, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd1);
      check($sformatf("vec%0d_gnt", v), 32'(g), 32'(vecs[v].gnt));
      wait_done(dur, leds, pat, d);
      check($sformatf("vec%0d_dur", v), 32'(dur), 32'(vecs[v].dur));
      check($sformatf("vec%0d_leds", v), 32'(leds), 32'(vecs[v].leds));
      check($sformatf("vec%0d_done", v), 32'(d), 32'(vecs[v].gnt));
      if (v == 0) check("vec0_led_pattern", 32'(pat), 32'h39C);
      req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
    end

    // Round robin with every requester re-competing after each done.
    do_reset();
    req     = 4'b1111;
    req_cnt = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, lat);
      check($sformatf("rr%0d_gnt", k), 32'(g), 32'(rr_exp[k]));
      check($sformatf("rr%0d_latency", k), 32'(lat), (k == 0) ? 32'd1 : 32'd2);
      wait_done(dur, leds, pat, d);
      check($sformatf("rr%0d_dur", k), 32'(dur), 32'd5);
      check($sformatf("rr%0d_done", k), 32'(d), 32'(rr_exp[k]));
    end

    // Withdrawal in the second ON cycle aborts without a done pulse.
    do_reset();
    req     = 4'b0010;
    req_cnt = 16'h0030;
    wait_grant(g, lat);
    check("abort_gnt", 32'(g), 32'b0010);
    @(negedge clk);
    check("abort_led_on", 32'(led), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("abort_outputs", 32'({gnt, busy, led}), 32'd0);
    dur = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != 4'b0000) dur++;
    end
    check("abort_no_done", 32'(dur), 32'd0);

    // Asynchronous reset in the OFF phase, then search restarts from requester 0.
    do_reset();
    req     = 4'b0001;
    req_cnt = 16'h0004;
    wait_grant(g, lat);
    repeat (3) @(negedge clk);
    check("rst_pre_off_busy", 32'({busy, led}), 32'b10);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", 32'({gnt, done, busy, led}), 32'd0);
    req     = 4'b1001;
    req_cnt = 16'h1001;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(g, lat);
    check("rst_ptr_gnt", 32'(g), 32'b0001);
    check("rst_latency", 32'(lat), 32'd1);
    wait_done(dur, leds, pat, d);
    check("rst_dur", 32'(dur), 32'd5);

    // Random traffic; the continuous comparator does the checking.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rnd_drive();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
